sm3_msg_padder_stream: RTL and testbench



---
 rtl/sm3_msg_padder_stream.sv | 213 +++++++++++++++++++++
 tb/tb_sm3_msg_padder_stream.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sm3_msg_padder_stream.sv
// Streaming SM3 message padder: packs WIDTH-bit message words into 512-bit blocks,
// appending the 0x80 marker, zero fill and the 64-bit big-endian bit length.
module sm3_msg_padder_stream #(
  parameter int WIDTH = 32
) (
  input  logic                         clk_in,
  input  logic                         reset_n_in,
  input  logic                         start_in,
  input  logic                         empty_msg_in,
  input  logic [WIDTH-1:0]             msg_in,
  input  logic                         msg_valid_in,
  output logic                         msg_ready_out,
  input  logic                         is_last_word_in,
  input  logic [$clog2(WIDTH/8)-1:0]   last_word_bytes_in,
  output logic [511:0]                 block_out,
  output logic                         block_valid_out,
  input  logic                         block_ready_in,
  output logic                         block_first_out,
  output logic                         block_last_out,
  output logic                         busy_out,
  output logic                         done_out
);

  localparam int NW     = 512 / WIDTH;
  localparam int BW     = $clog2(WIDTH / 8);
  localparam int NB     = WIDTH / 8;
  localparam int LENW   = 64 / WIDTH;
  localparam int PADEND = NW - LENW;
  localparam int WI     = $clog2(NW);

  localparam logic [WI-1:0]    PADEND_IDX = WI'(PADEND);
  localparam logic [WI-1:0]    LAST_IDX   = WI'(NW - 1);
  localparam logic [BW:0]      NB_B       = (BW + 1)'(NB);
  localparam logic [WIDTH-1:0] PAD_WORD   = {8'h80, {(WIDTH - 8){1'b0}}};

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_PAD,
    ST_LEN,
    ST_EMIT
  } state_t;

  state_t            state_reg;
  logic [WIDTH-1:0]  words_reg [NW];
  logic [WI-1:0]     widx_reg;
  logic [63:0]       bitlen_reg;
  logic              pad_pending_reg;
  logic              first_reg;
  logic              last_reg;
  logic              ended_reg;
  logic              msg_ready_reg;
  logic              block_valid_reg;
  logic              busy_reg;
  logic              done_reg;

  logic [BW:0]       last_bytes;
  logic [WIDTH-1:0]  last_word;
  logic [6:0]        len_shift;
  logic [WIDTH-1:0]  len_word;

  assign last_bytes = {1'b0, last_word_bytes_in} + (BW + 1)'(1);

  // Final word: keep the valid bytes, drop the marker right after them, zero the rest.
  genvar gi;
  generate
    for (gi = 0; gi < NB; gi++) begin : g_last_byte
      localparam logic [BW:0] GI_B = (BW + 1)'(gi);
      assign last_word[WIDTH-1-8*gi -: 8] =
        (GI_B < last_bytes)  ? msg_in[WIDTH-1-8*gi -: 8] :
        (GI_B == last_bytes) ? 8'h80 : 8'h00;
    end
  endgenerate

  // Length slice for the current length-field word, most significant half first.
  assign len_shift = 7'(LAST_IDX - widx_reg) * 7'(WIDTH);
  assign len_word  = WIDTH'(bitlen_reg >> len_shift);

  generate
    for (gi = 0; gi < NW; gi++) begin : g_block
      assign block_out[511-gi*WIDTH -: WIDTH] = words_reg[gi];
    end
  endgenerate

  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      state_reg       <= ST_IDLE;
      for (int i = 0; i < NW; i++) words_reg[i] <= '0;
      widx_reg        <= '0;
      bitlen_reg      <= '0;
      pad_pending_reg <= 1'b0;
      first_reg       <= 1'b0;
      last_reg        <= 1'b0;
      ended_reg       <= 1'b0;
      msg_ready_reg   <= 1'b0;
      block_valid_reg <= 1'b0;
      busy_reg        <= 1'b0;
      done_reg        <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (start_in) begin
            first_reg       <= 1'b1;
            last_reg        <= 1'b0;
            widx_reg        <= '0;
            bitlen_reg      <= '0;
            busy_reg        <= 1'b1;
            ended_reg       <= empty_msg_in;
            pad_pending_reg <= empty_msg_in;
            if (empty_msg_in) begin
              state_reg <= ST_PAD;
            end else begin
              state_reg     <= ST_LOAD;
              msg_ready_reg <= 1'b1;
            end
          end
        end

        ST_LOAD: begin
          if (msg_valid_in) begin
            if (is_last_word_in) begin
              words_reg[widx_reg] <= last_word;
              bitlen_reg          <= bitlen_reg + 64'({last_bytes, 3'b000});
              pad_pending_reg     <= (last_bytes == NB_B);
              ended_reg           <= 1'b1;
              msg_ready_reg       <= 1'b0;
              // A final word that fills the block flushes it before padding continues.
              if (widx_reg == LAST_IDX) begin
                state_reg       <= ST_EMIT;
                block_valid_reg <= 1'b1;
                last_reg        <= 1'b0;
              end else begin
                widx_reg  <= widx_reg + 1'b1;
                state_reg <= ST_PAD;
              end
            end else begin
              words_reg[widx_reg] <= msg_in;
              bitlen_reg          <= bitlen_reg + 64'(WIDTH);
              if (widx_reg == LAST_IDX) begin
                state_reg       <= ST_EMIT;
                msg_ready_reg   <= 1'b0;
                block_valid_reg <= 1'b1;
                last_reg        <= 1'b0;
              end else begin
                widx_reg <= widx_reg + 1'b1;
              end
            end
          end
        end

        ST_PAD: begin
          if (widx_reg == PADEND_IDX && !pad_pending_reg) begin
            state_reg <= ST_LEN;
          end else begin
            // Beyond the length field this fills the block with zeros and spills to a new one.
            words_reg[widx_reg] <= pad_pending_reg ? PAD_WORD : '0;
            pad_pending_reg     <= 1'b0;
            if (widx_reg == LAST_IDX) begin
              state_reg       <= ST_EMIT;
              block_valid_reg <= 1'b1;
              last_reg        <= 1'b0;
            end else begin
              widx_reg <= widx_reg + 1'b1;
            end
          end
        end

        ST_LEN: begin
          words_reg[widx_reg] <= len_word;
          if (widx_reg == LAST_IDX) begin
            state_reg       <= ST_EMIT;
            block_valid_reg <= 1'b1;
            last_reg        <= 1'b1;
          end else begin
            widx_reg <= widx_reg + 1'b1;
          end
        end

        ST_EMIT: begin
          if (block_ready_in) begin
            block_valid_reg <= 1'b0;
            widx_reg        <= '0;
            first_reg       <= 1'b0;
            last_reg        <= 1'b0;
            if (last_reg) begin
              state_reg <= ST_IDLE;
              busy_reg  <= 1'b0;
              done_reg  <= 1'b1;
            end else if (ended_reg) begin
              state_reg <= ST_PAD;
            end else begin
              state_reg     <= ST_LOAD;
              msg_ready_reg <= 1'b1;
            end
          end
        end

        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign msg_ready_out   = msg_ready_reg;
  assign block_valid_out = block_valid_reg;
  assign block_first_out = first_reg;
  assign block_last_out  = last_reg;
  assign busy_out        = busy_reg;
  assign done_out        = done_reg;

endmodule

// File: tb/tb_sm3_msg_padder_stream.sv
// Randomized bench for the SM3 padder: 32- and 64-bit instances checked against a
// byte-level padding model, plus directed abc, backpressure and reset cases.
module tb_sm3_msg_padder_stream;

  logic         clk_in = 1'b0;
  logic         reset_n_in;
  logic         start, empty, sel;
  logic [63:0]  msg_w;
  logic         valid, last_w, bready;
  logic [2:0]   lbytes;

  logic         r32, bv32, bf32, bl32, busy32, done32;
  logic [511:0] blk32;
  logic         r64, bv64, bf64, bl64, busy64, done64;
  logic [511:0] blk64;

  logic         m_ready, m_bvalid, m_first, m_last, m_busy, m_done;
  logic [511:0] m_blk;

  int checks = 0;
  int errors = 0;

  byte unsigned msg_q[$];
  logic [511:0] exp_q[$];
  logic [511:0] got_q[$];

  localparam logic [511:0] ABC = {32'h61626380, 416'h0, 64'h18};

  always #5 clk_in = ~clk_in;

  sm3_msg_padder_stream #(.WIDTH(32)) dut32 (
    .clk_in(clk_in), .reset_n_in(reset_n_in),
    .start_in(start & ~sel), .empty_msg_in(empty),
    .msg_in(msg_w[63:32]), .msg_valid_in(valid & ~sel), .msg_ready_out(r32),
    .is_last_word_in(last_w), .last_word_bytes_in(lbytes[1:0]),
    .block_out(blk32), .block_valid_out(bv32), .block_ready_in(bready & ~sel),
    .block_first_out(bf32), .block_last_out(bl32), .busy_out(busy32), .done_out(done32)
  );

  sm3_msg_padder_stream #(.WIDTH(64)) dut64 (
    .clk_in(clk_in), .reset_n_in(reset_n_in),
    .start_in(start & sel), .empty_msg_in(empty),
    .msg_in(msg_w), .msg_valid_in(valid & sel), .msg_ready_out(r64),
    .is_last_word_in(last_w), .last_word_bytes_in(lbytes),
    .block_out(blk64), .block_valid_out(bv64), .block_ready_in(bready & sel),
    .block_first_out(bf64), .block_last_out(bl64), .busy_out(busy64), .done_out(done64)
  );

  assign m_ready  = sel ? r64    : r32;
  assign m_bvalid = sel ? bv64   : bv32;
  assign m_first  = sel ? bf64   : bf32;
  assign m_last   = sel ? bl64   : bl32;
  assign m_busy   = sel ? busy64 : busy32;
  assign m_done   = sel ? done64 : done32;
  assign m_blk    = sel ? blk64  : blk32;

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", tag, got, exp);
    end
  endtask

  // Reference: pad the byte string per SM3 and cut it into 64-byte blocks.
  task automatic build_exp();
    byte unsigned pb[$];
    longint unsigned bits;
    bits = 64'(msg_q.size()) * 64'd8;
    pb = msg_q;
    pb.push_back(8'h80);
    while (pb.size() % 64 != 56) pb.push_back(8'h00);
    for (int j = 7; j >= 0; j--) pb.push_back(8'(bits >> (8 * j)));
    exp_q.delete();
    for (int b = 0; b < pb.size() / 64; b++) begin
      logic [511:0] v;
      v = '0;
      for (int j = 0; j < 64; j++) v[511-8*j -: 8] = pb[b*64+j];
      exp_q.push_back(v);
    end
  endtask

  task automatic run_msg(input int w, input int stall);
    int n, wb, nwords;
    n = msg_q.size();
    wb = w / 8;
    nwords = (n + wb - 1) / wb;
    sel = (w == 64);
    build_exp();
    got_q.delete();
    @(posedge clk_in); #1;
    start = 1'b1;
    empty = (n == 0);
    @(posedge clk_in); #1;
    start = 1'b0;
    empty = 1'b0;
    fork
      begin : drv
        for (int i = 0; i < nwords; i++) begin
          logic [63:0] wv;
          int rem, t;
          rem = n - i * wb;
          t = 0;
          repeat ($urandom_range(0, 2)) begin @(posedge clk_in); #1; end
          wv = {$urandom, $urandom};
          for (int j = 0; j < wb && j < rem; j++) wv[63-8*j -: 8] = msg_q[i*wb+j];
          msg_w  = wv;
          valid  = 1'b1;
          last_w = (i == nwords - 1);
          lbytes = last_w ? 3'(((rem < wb) ? rem : wb) - 1) : 3'($urandom);
          do begin
            @(negedge clk_in);
            t++;
          end while (!m_ready && t < 200);
          if (!m_ready) begin
            chk("drv_timeout", 0, 1);
            valid = 1'b0;
            break;
          end
          @(posedge clk_in); #1;
          valid  = 1'b0;
          last_w = 1'b0;
        end
      end
      begin : mon
        int blk, t, hold;
        bit hv, seen_last;
        logic [511:0] held;
        blk = 0; t = 0; hold = stall; hv = 0; seen_last = 0; held = '0;
        while (!seen_last && t < 3000) begin
          @(negedge clk_in);
          t++;
          if (hv) begin
            chk("hold_valid", 512'(m_bvalid), 1);
            chk("hold_block", m_blk, held);
            hv = 0;
          end
          if (m_bvalid) begin
            chk("ready_in_emit", 512'(m_ready), 0);
            if (hold > 0) begin
              hold--;
              bready = 1'b0;
            end else begin
              bready = ($urandom_range(0, 3) != 0);
            end
            if (bready) begin
              got_q.push_back(m_blk);
              if (blk < exp_q.size()) begin
                chk("block", m_blk, exp_q[blk]);
                chk("first", 512'(m_first), 512'(blk == 0));
                chk("last", 512'(m_last), 512'(blk == exp_q.size() - 1));
              end else begin
                chk("extra_block", 512'(blk), 512'(exp_q.size() - 1));
              end
              blk++;
              if (m_last) seen_last = 1;
            end else begin
              held = m_blk;
              hv = 1;
            end
          end else begin
            bready = $urandom_range(0, 1);
          end
        end
        if (!seen_last) chk("mon_timeout", 0, 1);
        chk("nblocks", 512'(blk), 512'(exp_q.size()));
        @(negedge clk_in);
        bready = 1'b0;
        chk("done_pulse", 512'(m_done), 1);
        chk("busy_after", 512'(m_busy), 0);
        @(negedge clk_in);
        chk("done_clear", 512'(m_done), 0);
      end
    join
    $display("msg w=%0d bytes=%0d blocks=%0d/%0d", w, n, got_q.size(), exp_q.size());
  endtask

  task automatic rand_msg(input int n);
    msg_q.delete();
    for (int i = 0; i < n; i++) msg_q.push_back(8'($urandom));
  endtask

  initial begin
    int lens[11];
    bit any;
    lens = '{55, 56, 57, 58, 63, 64, 65, 0, 119, 120, 128};
    reset_n_in = 1'b0;
    start = 0; empty = 0; sel = 0; msg_w = '0; valid = 0; last_w = 0; lbytes = '0; bready = 0;
    repeat (3) @(negedge clk_in);
    chk("rst_blk32", blk32, '0);
    chk("rst_blk64", blk64, '0);
    chk("rst_flags", 512'({r32, bv32, bf32, bl32, busy32, done32, r64, bv64, bf64, bl64, busy64, done64}), 0);
    reset_n_in = 1'b1;

    // "abc" with a long initial stall on the output
    msg_q = '{8'h61, 8'h62, 8'h63};
    run_msg(32, 10);
    chk("abc32", got_q.size() > 0 ? got_q[0] : '0, ABC);

    msg_q = '{8'h61, 8'h62, 8'h63};
    run_msg(64, 0);
    chk("abc64", got_q.size() > 0 ? got_q[0] : '0, ABC);

    for (int wi = 0; wi < 2; wi++) begin
      for (int li = 0; li < 11; li++) begin
        rand_msg(lens[li]);
        run_msg(wi ? 64 : 32, 0);
      end
    end

    repeat (16) begin
      rand_msg($urandom_range(0, 140));
      run_msg($urandom_range(0, 1) ? 64 : 32, $urandom_range(0, 3));
    end

    // Reset in the middle of loading a message
    sel = 1'b0;
    @(posedge clk_in); #1;
    start = 1'b1;
    @(posedge clk_in); #1;
    start = 1'b0;
    valid = 1'b1;
    last_w = 1'b0;
    msg_w = {$urandom, $urandom};
    repeat (2) begin
      @(posedge clk_in); #1;
      msg_w = {$urandom, $urandom};
    end
    valid = 1'b0;
    @(negedge clk_in);
    chk("pre_rst_busy", 512'(m_busy), 1);
    chk("pre_rst_ready", 512'(m_ready), 1);
    #2 reset_n_in = 1'b0;
    #1;
    chk("midrst_blk", m_blk, '0);
    chk("midrst_flags", 512'({m_ready, m_bvalid, m_first, m_last, m_busy, m_done}), 0);
    #3 reset_n_in = 1'b1;
    any = 0;
    bready = 1'b1;
    repeat (20) begin
      @(negedge clk_in);
      any |= m_bvalid | m_busy | m_done;
    end
    bready = 1'b0;
    chk("no_block_after_rst", 512'(any), 0);

    rand_msg(61);
    run_msg(32, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
